// File: rtl/data_mem_master.sv
// rtl/data_mem_master.sv - DataRAM initiator: single-word/burst load/store controller
// Optional feature macro: DMEM_BOUNDS_CHECK_EN (suppress beats at addresses >= DEPTH, sticky Err)
module data_mem_master #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 4,
  parameter int DEPTH  = 1024
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [LEN_W-1:0]  ReqLen,
  input  logic [DATA_W-1:0] WrData,
  input  logic              WrValid,
  output logic              WrReady,
  output logic [DATA_W-1:0] RdData,
  output logic              RdValid,
  input  logic              RdReady,
  output logic              Done,
  output logic              Err,
  output logic [ADDR_W-1:0] DataAddress,
  output logic              MemWrite,
  output logic [DATA_W-1:0] DataIn,
  input  logic [DATA_W-1:0] DataOut
);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;    // next address to write or to issue for a read
  logic [ADDR_W-1:0] slot_addr;   // address of the word sitting in the read output slot
  logic [ADDR_W-1:0] addr_q;      // last address driven, held while idle
  logic [LEN_W-1:0]  cnt;         // words remaining minus one
  logic              issue_done;  // every read address of the burst has been issued
  logic              slot_last;   // the word in the output slot is the final one
  logic              slot_oob;    // the word in the output slot was out of range
  logic [DATA_W-1:0] din_q;       // last written data, held outside store beats

  logic              wr_beat;
  logic              rd_take;
  logic              rd_stall;
  logic              rd_issue;
  logic              cur_oob;
  logic [ADDR_W-1:0] addr_now;

`ifdef DMEM_BOUNDS_CHECK_EN
  logic err_q;

  assign cur_oob = (32'(cur_addr) >= 32'(DEPTH));
  assign Err     = err_q;

  // Sticky out-of-range flag, cleared when the next request is accepted
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      err_q <= 1'b0;
    end else if (state == IDLE && ReqValid) begin
      err_q <= 1'b0;
    end else if ((wr_beat || rd_issue) && cur_oob) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_depth;

  assign cur_oob      = 1'b0;
  assign Err          = 1'b0;
  assign unused_depth = (DEPTH == 0);
`endif

  // Handshake qualifiers: a store beat, a read beat consumed, a stalled read
  // beat, and a new read address issued into the (free or draining) slot
  assign wr_beat  = (state == WR) && WrValid;
  assign rd_take  = (state == RD) && RdValid && RdReady;
  assign rd_stall = (state == RD) && RdValid && !RdReady;
  assign rd_issue = (state == RD) && !issue_done && (!RdValid || RdReady);

  // While a read beat is stalled the RAM must keep re-reading that word so
  // DataOut (and hence RdData) stays stable; otherwise present the next address.
  assign addr_now    = rd_stall ? slot_addr : cur_addr;
  assign DataAddress = (state == IDLE) ? addr_q : addr_now;

  // Write strobe is combinational from the registered state so an async reset
  // drops it immediately
  assign MemWrite = wr_beat && !cur_oob;
  assign DataIn   = wr_beat ? WrData : din_q;

  // The RAM output is returned directly; out-of-range beats read as zero
  assign RdData = (RdValid && !slot_oob) ? DataOut : '0;

  // Burst controller: request acceptance, store beats, read issue/return, Done
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= IDLE;
      ReqReady   <= 1'b1;
      WrReady    <= 1'b0;
      RdValid    <= 1'b0;
      Done       <= 1'b0;
      cur_addr   <= '0;
      slot_addr  <= '0;
      addr_q     <= '0;
      cnt        <= '0;
      issue_done <= 1'b0;
      slot_last  <= 1'b0;
      slot_oob   <= 1'b0;
      din_q      <= '0;
    end else begin
      Done <= 1'b0;
      if (state != IDLE) begin
        addr_q <= addr_now;
      end
      if (wr_beat) begin
        din_q <= WrData;
      end
      case (state)
        IDLE: begin
          if (ReqValid) begin
            cur_addr   <= ReqAddr;
            cnt        <= ReqLen;
            issue_done <= 1'b0;
            ReqReady   <= 1'b0;
            if (ReqWrite) begin
              state   <= WR;
              WrReady <= 1'b1;
            end else begin
              state <= RD;
            end
          end
        end
        WR: begin
          if (WrValid) begin
            cur_addr <= cur_addr + ADDR_W'(1);
            if (cnt == '0) begin
              state    <= IDLE;
              WrReady  <= 1'b0;
              ReqReady <= 1'b1;
              Done     <= 1'b1;
            end else begin
              cnt <= cnt - LEN_W'(1);
            end
          end
        end
        RD: begin
          if (rd_issue) begin
            RdValid   <= 1'b1;
            slot_addr <= cur_addr;
            slot_oob  <= cur_oob;
            slot_last <= (cnt == '0);
            cur_addr  <= cur_addr + ADDR_W'(1);
            if (cnt == '0) begin
              issue_done <= 1'b1;
            end else begin
              cnt <= cnt - LEN_W'(1);
            end
          end else if (rd_take) begin
            RdValid <= 1'b0;
            if (slot_last) begin
              state    <= IDLE;
              ReqReady <= 1'b1;
              Done     <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_master.sv
// tb/tb_data_mem_master.sv - self-checking bench for data_mem_master with a DataRAM model
module tb_data_mem_master;

  logic        CLK;
  logic        RSTn;
  logic        ReqValid, ReqReady, ReqWrite;
  logic [15:0] ReqAddr;
  logic [3:0]  ReqLen;
  logic [15:0] WrData;
  logic        WrValid, WrReady;
  logic [15:0] RdData;
  logic        RdValid, RdReady;
  logic        Done, Err;
  logic [15:0] DataAddress;
  logic        MemWrite;
  logic [15:0] DataIn;
  logic [15:0] DataOut;

  int checks = 0;
  int failures = 0;

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam int BOUND = 1024;
`else
  localparam int BOUND = 65536;
`endif

  data_mem_master dut (
    .CLK(CLK), .RSTn(RSTn),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqLen(ReqLen),
    .WrData(WrData), .WrValid(WrValid), .WrReady(WrReady),
    .RdData(RdData), .RdValid(RdValid), .RdReady(RdReady),
    .Done(Done), .Err(Err),
    .DataAddress(DataAddress), .MemWrite(MemWrite), .DataIn(DataIn), .DataOut(DataOut)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // DataRAM: synchronous read, write on MemWrite
  logic [15:0] ram [0:65535];
  always @(posedge CLK) begin
    if (MemWrite) ram[DataAddress] <= DataIn;
    DataOut <= ram[DataAddress];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit oob(input logic [15:0] a);
    return 32'(a) >= BOUND;
  endfunction

  // Reference model: expected memory contents, outstanding burst, expected beats
  logic [15:0] gold [0:65535];
  logic [15:0] wq [$];
  logic [15:0] rq [$];
  int          outstanding = 0;
  bit          mode_wr = 1'b0;
  int          rd_cd = 0;
  logic [15:0] ma;
  bit          exp_wr;

  always @(negedge CLK) begin
    if (!RSTn) begin
      wq.delete(); rq.delete();
      outstanding = 0; rd_cd = 0;
      chk("rst_req_ready", ReqReady, 1);
      chk("rst_wr_ready", WrReady, 0);
      chk("rst_rd_valid", RdValid, 0);
      chk("rst_done", Done, 0);
      chk("rst_err", Err, 0);
      chk("rst_mem_write", MemWrite, 0);
      chk("rst_data_address", DataAddress, 0);
      chk("rst_data_in", DataIn, 0);
      chk("rst_rd_data", RdData, 0);
    end else begin
      if (rd_cd > 0) rd_cd--;
      if (Done) begin
        chk("done_legal", (outstanding > 0 && wq.size() == 0 && rq.size() == 0), 1);
        if (outstanding > 0) outstanding--;
      end
      chk("req_ready", ReqReady, (outstanding == 0));
      exp_wr = (outstanding > 0) && mode_wr && (wq.size() > 0);
      chk("wr_ready", WrReady, exp_wr);
      chk("rd_valid", RdValid, (outstanding > 0) && !mode_wr && (rq.size() > 0) && (rd_cd == 0));
      if (RdValid && rq.size() > 0) begin
        chk("rd_data", RdData, rq[0]);
        if (RdReady) void'(rq.pop_front());
      end
      if (WrValid && exp_wr) begin
        ma = wq.pop_front();
        chk("mem_write", MemWrite, !oob(ma));
        if (!oob(ma)) begin
          chk("wr_address", DataAddress, ma);
          chk("wr_data_in", DataIn, WrData);
          gold[ma] = WrData;
        end
      end else begin
        chk("mem_write_idle", MemWrite, 0);
      end
`ifndef DMEM_BOUNDS_CHECK_EN
      chk("err_zero", Err, 0);
`endif
      if (ReqValid && outstanding == 0) begin
        outstanding = 1;
        mode_wr = ReqWrite;
        rd_cd = 2;
        for (int i = 0; i <= int'(ReqLen); i++) begin
          ma = ReqAddr + 16'(i);
          if (ReqWrite) wq.push_back(ma);
          else rq.push_back(oob(ma) ? 16'h0000 : gold[ma]);
        end
      end
    end
  end

  // Stimulus helpers
  logic [15:0] sdat [0:15];
  logic [15:0] rbeat [0:15];
  int rcount, first_cyc, done_cyc;

  task automatic request(input bit w, input logic [15:0] a, input int n);
    int t = 0;
    while (!ReqReady && t < 100) begin
      @(posedge CLK); #1; t++;
    end
    chk("req_ready_wait", ReqReady, 1);
    ReqValid = 1'b1; ReqWrite = w; ReqAddr = a; ReqLen = 4'(n - 1);
    @(posedge CLK); #1;
    ReqValid = 1'b0; ReqWrite = 1'($urandom); ReqAddr = 16'($urandom); ReqLen = 4'($urandom);
  endtask

  // gap: 0 continuous, 1 every other cycle, 2 random; poke drives ReqValid mid-burst
  task automatic store_burst(input logic [15:0] a, input int n, input int gap, input bit poke);
    int i = 0;
    int t = 0;
    bit hs;
    request(1'b1, a, n);
    while (i < n && t < 200) begin
      case (gap)
        0: WrValid = 1'b1;
        1: WrValid = (t % 2 == 1);
        default: WrValid = ($urandom_range(0, 1) == 1);
      endcase
      WrData = sdat[i];
      ReqValid = poke && (i == 1);
      @(negedge CLK);
      hs = WrValid && WrReady;
      @(posedge CLK); #1;
      t++;
      if (hs) i++;
    end
    WrValid = 1'b0; ReqValid = 1'b0; WrData = 16'($urandom);
    chk("wr_beats", i, n);
    chk("wr_done_pulse", Done, 1);
  endtask

  // mode: 0 always ready, 1 random ready, 2 stall three cycles on the second beat
  task automatic load_burst(input logic [15:0] a, input int n, input int mode);
    int t = 0;
    int stalls = 0;
    bit seen = 1'b0;
    rcount = 0; first_cyc = -1; done_cyc = -1;
    request(1'b0, a, n);
    while (!seen && t < 300) begin
      case (mode)
        0: RdReady = 1'b1;
        1: RdReady = ($urandom_range(0, 3) != 0);
        default: begin
          RdReady = !(rcount == 1 && RdValid && stalls < 3);
          if (!RdReady) stalls++;
        end
      endcase
      @(negedge CLK);
      if (Done) begin seen = 1'b1; done_cyc = t; end
      if (RdValid && first_cyc < 0) first_cyc = t;
      if (RdValid && RdReady) begin
        if (rcount < 16) rbeat[rcount] = RdData;
        rcount++;
      end
      @(posedge CLK); #1;
      t++;
    end
    RdReady = 1'($urandom);
    chk("rd_done_seen", seen, 1);
    chk("rd_count", rcount, n);
  endtask

  logic [15:0] ra, d0, d1;
  int rn, roff, rl;

  initial begin
    RSTn = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = '0; ReqLen = '0;
    WrData = '0; WrValid = 1'b0; RdReady = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK); #2 RSTn = 1'b1;
    @(posedge CLK); #1;
    chk("post_rst_req_ready", ReqReady, 1);
    chk("post_rst_done", Done, 0);
    chk("post_rst_rd_data", RdData, 0);

    // Single store / load
    sdat[0] = 16'hFFFF;
    store_burst(16'd1, 1, 0, 1'b0);
    load_burst(16'd1, 1, 0);
    chk("single_rd_data", rbeat[0], 16'hFFFF);
    chk("single_first_cyc", first_cyc, 1);
    chk("single_done_cyc", done_cyc, 2);

    // Burst store with gapped WrValid and a stray request, then burst load
    sdat[0] = 16'h1111; sdat[1] = 16'h2222; sdat[2] = 16'h3333; sdat[3] = 16'h4444;
    store_burst(16'd32, 4, 1, 1'b1);
    load_burst(16'd32, 4, 0);
    chk("burst_beat0", rbeat[0], 16'h1111);
    chk("burst_beat1", rbeat[1], 16'h2222);
    chk("burst_beat2", rbeat[2], 16'h3333);
    chk("burst_beat3", rbeat[3], 16'h4444);
    chk("burst_first_cyc", first_cyc, 1);
    chk("burst_done_cyc", done_cyc, 5);

    // Backpressure on the second beat
    load_burst(16'd32, 3, 2);
    chk("bp_beat0", rbeat[0], 16'h1111);
    chk("bp_beat1", rbeat[1], 16'h2222);
    chk("bp_beat2", rbeat[2], 16'h3333);
    chk("bp_done_cyc", done_cyc, 7);

    // Address wrap
    sdat[0] = 16'hA5A5; sdat[1] = 16'h5A5A;
    store_burst(16'hFFFF, 2, 0, 1'b0);
`ifdef DMEM_BOUNDS_CHECK_EN
    chk("wrap_err", Err, 1);
`endif
    load_burst(16'hFFFF, 2, 0);
`ifdef DMEM_BOUNDS_CHECK_EN
    chk("wrap_beat0", rbeat[0], 16'h0000);
`else
    chk("wrap_beat0", rbeat[0], 16'hA5A5);
`endif
    chk("wrap_beat1", rbeat[1], 16'h5A5A);

    // Reset in the middle of a store burst
    d0 = 16'hBEEF; d1 = 16'hCAFE;
    request(1'b1, 16'd100, 4);
    WrValid = 1'b1; WrData = d0;
    @(posedge CLK); #1 WrData = d1;
    @(posedge CLK); #1 WrData = 16'h0BAD;
    #1 chk("pre_rst_mem_write", MemWrite, 1);
    #1 RSTn = 1'b0;
    #1 chk("rst_async_mem_write", MemWrite, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); #2 RSTn = 1'b1; WrValid = 1'b0;
    @(posedge CLK); #1;
    chk("abort_req_ready", ReqReady, 1);
    chk("abort_wr_ready", WrReady, 0);
    chk("abort_done", Done, 0);
    load_burst(16'd100, 2, 0);
    chk("abort_kept0", rbeat[0], d0);
    chk("abort_kept1", rbeat[1], d1);

    // Randomized store/load pairs checked by the model
    for (int it = 0; it < 30; it++) begin
      rn = $urandom_range(1, 16);
`ifdef DMEM_BOUNDS_CHECK_EN
      ra = 16'($urandom_range(0, 1100));
`else
      ra = 16'($urandom);
`endif
      for (int k = 0; k < 16; k++) sdat[k] = 16'($urandom);
      store_burst(ra, rn, 2, 1'($urandom));
      roff = $urandom_range(0, rn - 1);
      rl = $urandom_range(1, rn - roff);
      load_burst(ra + 16'(roff), rl, (it % 4 == 0) ? 0 : 1);
    end

    repeat (3) @(posedge CLK);
    chk("final_idle", outstanding, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
